// File: rtl/image_ram_arbiter_if.sv
// Camera write stream, VGA read path and single-port RAM signals shared by the image RAM arbiter.
interface image_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 24
);
    logic              w_valid;
    logic              w_sof;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // Client/RAM-model side: drives requests and RAM read data.
    modport master (
        output w_valid, w_sof, w_data, r_req, r_addr, ram_q,
        input  w_ready, r_valid, r_data, ram_addr, ram_data, ram_wren
    );

    // Arbiter side.
    modport slave (
        input  w_valid, w_sof, w_data, r_req, r_addr, ram_q,
        output w_ready, r_valid, r_data, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/image_ram_arbiter.sv
// Image RAM arbiter: VGA reads take priority over camera writes; capture FSM fills one frame.
// Optional macro STALL_CNT_EN adds o_stall_cnt (camera stall cycles while armed/capturing).
module image_ram_arbiter #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_capture,
    input  logic                i_abort,
    image_ram_arbiter_if.slave  bus,
    output logic [1:0]          o_state,
    output logic [ADDR_W:0]     o_wr_count,
    output logic                o_frame_done
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]         o_stall_cnt
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wr_addr_q, wr_addr_d;
    logic [RD_LAT-1:0]  rvalid_sr_q, rvalid_sr_d;
    logic               frame_done_q, frame_done_d;
    logic               arm_entry_c;

    logic               w_ready_c;
    logic               accept_c;
    logic               write_en_c;
    logic [ADDR_W-1:0]  wr_target_c;

    // State register and read-valid delay line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            rvalid_sr_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rvalid_sr_q  <= rvalid_sr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: abort beats capture, capture beats beat handling.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        arm_entry_c  = 1'b0;
        if (i_abort) begin
            state_d   = S_IDLE;
            wr_addr_d = '0;
        end else if (i_capture) begin
            state_d     = S_ARMED;
            wr_addr_d   = '0;
            arm_entry_c = 1'b1;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (accept_c && bus.w_sof) begin
                        state_d   = S_CAPTURE;
                        wr_addr_d = CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (accept_c) begin
                        if (bus.w_sof) begin
                            wr_addr_d = CNT_W'(1);
                        end else if (wr_addr_q == LAST_ADDR) begin
                            state_d      = S_DONE;
                            wr_addr_d    = FULL_CNT;
                            frame_done_d = 1'b1;
                        end else begin
                            wr_addr_d = wr_addr_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        rvalid_sr_d    = rvalid_sr_q;
        rvalid_sr_d[0] = bus.r_req;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            rvalid_sr_d[i] = rvalid_sr_q[i-1];
        end
    end

    // Output decode: write acceptance and the address a write lands on (SOF always lands on 0).
    always_comb begin
        w_ready_c   = !bus.r_req && (state_q == S_ARMED || state_q == S_CAPTURE);
        accept_c    = bus.w_valid && w_ready_c;
        write_en_c  = 1'b0;
        wr_target_c = wr_addr_q[ADDR_W-1:0];
        if (accept_c && !i_abort) begin
            case (state_q)
                S_ARMED: begin
                    write_en_c  = bus.w_sof;
                    wr_target_c = '0;
                end
                S_CAPTURE: begin
                    write_en_c = 1'b1;
                    if (bus.w_sof) wr_target_c = '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.w_ready  = w_ready_c;
    assign bus.ram_addr = bus.r_req ? bus.r_addr : wr_target_c;
    assign bus.ram_data = bus.w_data;
    assign bus.ram_wren = write_en_c;
    assign bus.r_valid  = rvalid_sr_q[RD_LAT-1];
    assign bus.r_data   = bus.ram_q;

    assign o_state      = state_q;
    assign o_wr_count   = wr_addr_q;
    assign o_frame_done = frame_done_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of camera beats held off by reads while armed/capturing.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (arm_entry_c) begin
            stall_cnt_d = '0;
        end else if (bus.w_valid && !w_ready_c &&
                     (state_q == S_ARMED || state_q == S_CAPTURE) &&
                     stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter: vector table, frame sequences, write/read scoreboards.
module tb_image_ram_arbiter;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned RD_LAT = 2;
    localparam logic [ADDR_W-1:0] RD_ADDR = 14'h0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture = 1'b0;
    logic abort = 1'b0;
    logic [1:0] st;
    logic [ADDR_W:0] wr_count;
    logic frame_done;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    image_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    image_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_capture    (capture),
        .i_abort      (abort),
        .bus          (bus),
        .o_state      (st),
        .o_wr_count   (wr_count),
        .o_frame_done (frame_done)
`ifdef STALL_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input int a);
        return DATA_W'((a * 40503) ^ 32'h005A5A5A);
    endfunction

    // RAM model: unwritten words read back as pat(addr).
    bit [DATA_W-1:0] mem     [2**ADDR_W];
    bit              written [2**ADDR_W];
    bit [ADDR_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_addr]     <= bus.ram_data;
            written[bus.ram_addr] <= 1'b1;
        end
        rd_pipe[0] <= bus.ram_addr;
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_q = written[rd_pipe[RD_LAT-1]] ? mem[rd_pipe[RD_LAT-1]] : pat(int'(rd_pipe[RD_LAT-1]));

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wq[$];
    logic [DATA_W-1:0] rq[$];
    int n_checks = 0;
    int n_fail = 0;
    int fd_pulses = 0;
    int rv_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the inactive edge.
    wr_t               mon_w;
    logic [DATA_W-1:0] mon_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_wren) begin
                if (wq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h", bus.ram_addr, bus.ram_data);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", 32'(bus.ram_addr), 32'(mon_w.addr));
                    chk("wr_data", 32'(bus.ram_data), 32'(mon_w.data));
                end
            end
            if (bus.r_valid) begin
                rv_count++;
                if (rq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_r_valid: data %0h", bus.r_data);
                end else begin
                    mon_r = rq.pop_front();
                    chk("r_data", 32'(bus.r_data), 32'(mon_r));
                end
            end
            if (frame_done) fd_pulses++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sof, input logic [DATA_W-1:0] data, input int addr, input bit exp_wr);
        wr_t e;
        bus.w_valid = 1'b1;
        bus.w_sof   = sof;
        bus.w_data  = data;
        if (exp_wr) begin
            e.addr = ADDR_W'(addr);
            e.data = data;
            wq.push_back(e);
        end
        step();
        bus.w_valid = 1'b0;
        bus.w_sof   = 1'b0;
    endtask

    typedef struct {
        bit         cap, abt, wv, sof, rr;
        logic [1:0] st;
        int         cnt;
        bit         rdy, wren;
    } vec_t;

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t e;
        int fd_base;
        //            cap abt wv sof rr  st cnt rdy wren
        vt[0]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 0, 0, 2'd0, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0, 2'd0, 0, 0, 0};
        vt[3]  = '{0, 0, 1, 0, 0, 2'd1, 0, 1, 0};
        vt[4]  = '{0, 0, 1, 0, 0, 2'd1, 0, 1, 0};
        vt[5]  = '{0, 0, 1, 0, 0, 2'd1, 0, 1, 0};
        vt[6]  = '{0, 0, 1, 0, 0, 2'd1, 0, 1, 0};
        vt[7]  = '{0, 0, 1, 0, 0, 2'd1, 0, 1, 0};
        vt[8]  = '{0, 0, 1, 1, 0, 2'd1, 0, 1, 1};
        vt[9]  = '{0, 0, 1, 0, 0, 2'd2, 1, 1, 1};
        vt[10] = '{0, 0, 1, 0, 1, 2'd2, 2, 0, 0};
        vt[11] = '{0, 1, 1, 0, 0, 2'd2, 2, 1, 0};
        vt[12] = '{0, 0, 1, 0, 0, 2'd0, 0, 0, 0};

        bus.w_valid = 1'b0; bus.w_sof = 1'b0; bus.w_data = '0;
        bus.r_req = 1'b0; bus.r_addr = RD_ADDR;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(st), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        chk("rst_r_valid", 32'(bus.r_valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        step();

        // Vector table: one row per cycle, outputs sampled mid-cycle
        for (int i = 0; i < 13; i++) begin
            capture = vt[i].cap; abort = vt[i].abt;
            bus.w_valid = vt[i].wv; bus.w_sof = vt[i].sof; bus.r_req = vt[i].rr;
            bus.w_data = DATA_W'(24'h100000 + i);
            if (vt[i].wren) begin
                e.addr = vt[i].sof ? '0 : ADDR_W'(vt[i].cnt);
                e.data = bus.w_data;
                wq.push_back(e);
            end
            if (vt[i].rr) rq.push_back(pat(int'(RD_ADDR)));
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), 32'(st), 32'(vt[i].st));
            chk($sformatf("vec%0d_wr_count", i), 32'(wr_count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_w_ready", i), 32'(bus.w_ready), 32'(vt[i].rdy));
            chk($sformatf("vec%0d_ram_wren", i), 32'(bus.ram_wren), 32'(vt[i].wren));
            if (vt[i].rr) chk($sformatf("vec%0d_ram_addr", i), 32'(bus.ram_addr), 32'(RD_ADDR));
            step();
        end
        capture = 0; abort = 0; bus.w_valid = 0; bus.w_sof = 0; bus.r_req = 0;
        step(); step();

        // Full frame with a 3-cycle read burst in the middle
        fd_pulses = 0; rv_count = 0;
        capture = 1; step(); capture = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 20) begin
                for (int k = 0; k < 3; k++) begin
                    bus.r_req = 1; bus.r_addr = RD_ADDR; bus.w_valid = 1; bus.w_data = 24'h300000 + 24'(i);
                    rq.push_back(pat(int'(RD_ADDR)));
                    @(negedge clk);
                    chk("burst_w_ready", 32'(bus.w_ready), 0);
                    chk("burst_ram_addr", 32'(bus.ram_addr), 32'(RD_ADDR));
                    step();
                end
                bus.r_req = 0;
            end
            beat(i == 0, (i == 0) ? 24'hABCDEF : 24'h300000 + 24'(i), i, 1'b1);
        end
        chk("frame_state", 32'(st), 3);
        chk("frame_wr_count", 32'(wr_count), DEPTH);
        chk("frame_done_pulse", 32'(frame_done), 1);
        bus.w_valid = 1;
        @(negedge clk);
        chk("done_w_ready", 32'(bus.w_ready), 0);
        step();
        bus.w_valid = 0;
        chk("frame_done_drop", 32'(frame_done), 0);
        bus.r_req = 1; bus.r_addr = '0; rq.push_back(24'hABCDEF); step();
        bus.r_addr = ADDR_W'(DEPTH - 1); rq.push_back(24'h300000 + 24'(DEPTH - 1)); step();
        bus.r_req = 0;
        repeat (4) step();
        chk("frame_done_count", 32'(fd_pulses), 1);
        chk("burst_r_valid_count", 32'(rv_count), 5);

        // SOF resync at wr_addr 50, then SOF on the last beat
        capture = 1; step(); capture = 0;
        beat(1'b1, 24'h400000, 0, 1'b1);
        for (int i = 1; i < 50; i++) beat(1'b0, 24'h400000 + 24'(i), i, 1'b1);
        chk("resync_pre_count", 32'(wr_count), 50);
        beat(1'b1, 24'h4AAAAA, 0, 1'b1);
        chk("resync_count", 32'(wr_count), 1);
        chk("resync_state", 32'(st), 2);
        for (int i = 1; i < int'(DEPTH) - 1; i++) beat(1'b0, 24'h500000 + 24'(i), i, 1'b1);
        chk("last_pre_count", 32'(wr_count), DEPTH - 1);
        fd_base = fd_pulses;
        beat(1'b1, 24'h5BBBBB, 0, 1'b1);
        chk("sof_last_count", 32'(wr_count), 1);
        chk("sof_last_state", 32'(st), 2);
        step();
        chk("sof_last_no_done", 32'(fd_pulses - fd_base), 0);

        // Abort together with an accepted beat at wr_addr 10
        for (int i = 1; i < 10; i++) beat(1'b0, 24'h600000 + 24'(i), i, 1'b1);
        chk("abort_pre_count", 32'(wr_count), 10);
        abort = 1;
        bus.w_valid = 1; bus.w_data = 24'h6FFFFF;
        @(negedge clk);
        chk("abort_w_ready", 32'(bus.w_ready), 1);
        chk("abort_no_wren", 32'(bus.ram_wren), 0);
        step();
        abort = 0;
        chk("abort_state", 32'(st), 0);
        chk("abort_count", 32'(wr_count), 0);
        @(negedge clk);
        chk("idle_w_ready", 32'(bus.w_ready), 0);
        step();
        bus.w_valid = 0;

`ifdef STALL_CNT_EN
        // Stall counter: 20 read-blocked beats in CAPTURE, cleared on re-arm
        capture = 1; step(); capture = 0;
        chk("stall_arm_clear", 32'(stall_cnt), 0);
        beat(1'b1, 24'h700000, 0, 1'b1);
        bus.r_req = 1; bus.r_addr = RD_ADDR; bus.w_valid = 1;
        for (int k = 0; k < 20; k++) begin
            rq.push_back(pat(int'(RD_ADDR)));
            step();
        end
        bus.r_req = 0; bus.w_valid = 0;
        chk("stall_count", 32'(stall_cnt), 20);
        capture = 1; step(); capture = 0;
        chk("stall_rearm", 32'(stall_cnt), 0);
        repeat (3) step();
`endif

        // Asynchronous reset in the middle of a capture with reads in flight
        capture = 1; step(); capture = 0;
        beat(1'b1, 24'h800000, 0, 1'b1);
        beat(1'b0, 24'h800001, 1, 1'b1);
        bus.r_req = 1; bus.r_addr = RD_ADDR;
        rq.push_back(pat(int'(RD_ADDR))); step();
        rq.push_back(pat(int'(RD_ADDR))); step();
        rq.push_back(pat(int'(RD_ADDR)));
        chk("pre_rst_r_valid", 32'(bus.r_valid), 1);
        chk("pre_rst_state", 32'(st), 2);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_state", 32'(st), 0);
        chk("async_rst_count", 32'(wr_count), 0);
        chk("async_rst_r_valid", 32'(bus.r_valid), 0);
        rq.delete();
        bus.r_req = 0;
        step(); step();
        rst_n = 1;
        repeat (3) step();
        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/image_ram_arbiter.md
Name: image_ram_arbiter

Overview:
Shares the single-port 24-bit image RAM between the camera write stream and the VGA read path. VGA reads always have priority. Camera writes are accepted only when no read is requested. A capture state machine arms on a command, aligns to start-of-frame, fills DEPTH words at auto-incremented addresses, then stops and holds the frame for display.

Parameters:
ADDR_W, 14, RAM address width
DATA_W, 24, pixel/RAM data width
DEPTH, 16384, words per frame; must be ≤ 2^ADDR_W and ≥ 2
RD_LAT, 1, RAM read latency in cycles (q valid RD_LAT cycles after address); ≥ 1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_capture  in  1  pulse: arm a frame capture
i_abort  in  1  pulse: cancel capture, return to IDLE
w_valid  in  1  camera beat valid
w_sof  in  1  beat is first pixel of a frame
w_data  in  DATA_W  camera pixel
w_ready  out  1  camera beat accepted when w_valid&w_ready
r_req  in  1  VGA read request (always granted)
r_addr  in  ADDR_W  VGA read address
r_valid  out  1  r_data valid
r_data  out  DATA_W  read pixel
ram_addr  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data
o_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
o_wr_count  out  ADDR_W+1  current write address / words written this frame
o_frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk. Reset values: state IDLE, wr_addr 0, r_valid 0, o_frame_done 0, RD_LAT delay line cleared.
- RAM side is combinational from registered state and inputs: ram_addr = r_req ? r_addr : wr_addr[ADDR_W-1:0]; ram_data = w_data; ram_wren = w_valid & w_ready & write_en.
- Read path: r_valid = r_req delayed RD_LAT cycles through a shift register; r_data = ram_q with no register; reads are legal in every state.
- w_ready = !r_req & (state==ARMED | state==CAPTURE); 0 in IDLE and DONE.
- IDLE: i_capture -> ARMED, wr_addr := 0.
- ARMED: an accepted non-SOF beat is dropped (write_en=0). An accepted SOF beat writes address 0 -> CAPTURE, wr_addr := 1.
- CAPTURE: every accepted beat writes wr_addr, then wr_addr += 1. An accepted SOF beat resyncs: it writes address 0, wr_addr := 1, state stays CAPTURE. An accepted non-SOF beat at wr_addr == DEPTH-1 writes, then state -> DONE, wr_addr := DEPTH, and o_frame_done pulses high for 1 cycle on the next clock.
- DONE: frame held, no writes; i_capture -> ARMED, wr_addr := 0.
- i_abort, any state: -> IDLE, wr_addr := 0. It overrides i_capture and suppresses any write in the same cycle (write_en=0).
- i_capture in ARMED or CAPTURE restarts arming: -> ARMED, wr_addr := 0.
- SOF on the DEPTH-1 beat: SOF wins (address 0, no frame_done).
- o_wr_count = wr_addr; o_state = encoded state.
- Asynchronous reset mid-capture: all state cleared immediately, r_valid drops; any partial frame in RAM is left as is.

Optional Feature:
STALL_CNT_EN: when defined, adds output o_stall_cnt[15:0]. It increments each cycle with w_valid & !w_ready & state∈{ARMED,CAPTURE}, saturates at 16'hFFFF, and clears on reset and on entry to ARMED. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, i_capture, then w_sof beat with 0xABCDEF followed by DEPTH-1 beats, r_req=0 -> RAM addr 0..DEPTH-1 written in order; o_frame_done pulses once; o_state=3; o_wr_count=DEPTH.
- In ARMED, 5 non-SOF beats then SOF -> no ram_wren for the 5; SOF beat written to addr 0; state CAPTURE.
- During CAPTURE, hold r_req=1 with r_addr=0x0100 for 3 cycles -> w_ready=0 for those 3 cycles; ram_addr=0x0100; r_valid high RD_LAT cycles later for 3 cycles; no write address skipped.
- At wr_addr=50, accepted SOF beat -> addr 0 written, o_wr_count=1 next cycle, state stays CAPTURE.
- i_abort asserted together with an accepted beat at wr_addr=10 -> no write; state IDLE; o_wr_count=0; then w_valid gives w_ready=0.
- STALL_CNT_EN defined, r_req held 20 cycles with w_valid=1 in CAPTURE -> o_stall_cnt=20; i_capture -> o_stall_cnt=0.
